spi_slv16: RTL and testbench
============================

# spi_slv16

SPI responder that forms the far end of the team's 16-bit SPI master link: it receives a 16-bit word on MOSI while returning a 16-bit word on MISO. Mode is CPOL=1, CPHA=1 with MSB first, and SCLK idles high. The master changes data on SCLK falling edges and samples on rising edges. All SPI pins are asynchronous to `clk` and are oversampled. The block sits on the peripheral side, for example inside a sensor model or register front end, and hands completed words to local logic with a one-cycle strobe.

## Interface
- `WIDTH`, 16, frame length in bits; also the width of `tx_data` and `rx_data`.
- `clk`  in  1  system clock; every register in the block uses it.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `SS_n`  in  1  slave select, active-low, asynchronous to `clk`.
- `SCLK`  in  1  serial clock, idles high, asynchronous to `clk`.
- `MOSI`  in  1  serial data in, asynchronous to `clk`.
- `MISO`  out  1  serial data out. It is `1'bz` whenever raw `SS_n` is high; otherwise it is `tx_shft[WIDTH-1]`.
- `tx_data`  in  WIDTH  word to return. Local logic must hold it stable from before `SS_n` falls until the frame load.
- `rx_data`  out  WIDTH  last good received word; it holds its value until the next good frame.
- `rdy`  out  1  one-cycle pulse when `rx_data` is updated.
- `err`  out  1  one-cycle pulse when a frame ends with a bit count other than WIDTH.

## Operation
**Input conditioning**
- `SS_n` and `SCLK` each pass through a 2-flop synchronizer followed by a history flop.
- Synchronizer and history flops for `SS_n` and `SCLK` reset to 1, so no false edge is seen out of reset.
- `MOSI` passes through a 2-flop synchronizer that resets to 0. This keeps it aligned with the synchronized `SCLK`.
- Edge flags are combinational from the synchronized value and the history flop: `ss_fall`, `ss_rise`, `sclk_rise`, `sclk_fall`.

**States**
- IDLE
  - `ss_fall`: load `tx_shft <= tx_data`, clear `rx_shft` and `bit_cnt`, go to ACTIVE.
  - Ignore all SCLK edges.
- ACTIVE
  - `sclk_rise`: `rx_shft <= {rx_shft[WIDTH-2:0], mosi_s}`. `bit_cnt` increments and saturates at 31; it is 5 bits wide.
  - `sclk_fall` with `bit_cnt != 0`: `tx_shft <= {tx_shft[WIDTH-2:0], 1'b0}`. The first falling edge does not shift, because bit WIDTH-1 is already on MISO.
  - `ss_rise`: if `bit_cnt == WIDTH`, set `rx_data <= rx_shft` and pulse `rdy`; otherwise pulse `err` and leave `rx_data` unchanged. Go to IDLE.

**Boundary conditions**
- If `ss_rise` coincides with `sclk_rise`, the shift is applied first and `ss_rise` evaluates the updated count.
- More than WIDTH rising edges in one frame gives `err`.
- Zero rising edges in one frame gives `err`.
- An SS_n pulse that is high for only one `clk` may be missed. The master guarantees SS_n stays high for at least 3 `clk`.
- Reset mid-frame:
  - All state is cleared and the block returns to IDLE.
  - `rdy` and `err` stay 0.
  - The remainder of the frame is ignored until the next `ss_fall`.

**Reset values**
- Outputs: `rx_data = 0`, `rdy = 0`, `err = 0`.
- Internal: `tx_shft = 0`, `rx_shft = 0`, `bit_cnt = 0`, state IDLE.
- `MISO` follows raw `SS_n`: it is `z` while `SS_n` is high.

## Timing
- Pin-to-action latency: a pin transition before clk edge k is acted on at edge k+2. Consequences:
  - `rdy`/`err` are high for exactly the cycle after edge k+2, where k is the first edge that sees `SS_n` high.
  - MISO updates 3 `clk` after the SCLK falling edge on the pin.
- Minimum SCLK high time and low time is 4 `clk`. The existing master uses 16 `clk`, which meets this.
- MOSI must be stable from 2 `clk` before to 2 `clk` after each SCLK rising edge on the pin.
- `tx_data` is sampled at edge k+2 after `SS_n` falls.
- The first MISO bit is valid from that edge until the first shift.
- Back-to-back frames are legal once `SS_n` has been high for at least 3 `clk`.

## Structure
- Package `spi_pkg` holds:
  - `SPI_WIDTH = 16`.
  - The state typedef `spi_slv_state_t` with values `IDLE` and `ACTIVE`.
  - `SYNC_STAGES = 2`.
- Sub-module `sync_edge_det`: a 2-flop synchronizer plus history flop with a reset-value parameter. It outputs the synced value, `rise` and `fall`. Instantiate it for `SS_n` and `SCLK`. MOSI uses only the synchronizer part.

## Test plan
- Frame exchange: reset, `tx_data = 16'hA5C3`; master sends `16'h1234` at 32 clk per SCLK period. Required response:
  - MISO bit sequence is A5C3 MSB first when sampled on SCLK rising edges.
  - `rx_data = 16'h1234`, with one `rdy` pulse 3 clk after `SS_n` rises.
- Back-to-back frames: `16'hFFFF` then `16'h0001` with 3 clk of `SS_n` high between them. Required response: two `rdy` pulses, and `rx_data` ends at `16'h0001`.
- Short frame: 15 SCLK cycles then `SS_n` rises. Required response: an `err` pulse, no `rdy`, and `rx_data` keeps its previous value.
- Long frame: 17 cycles. Required response: `err` pulse, `rx_data` unchanged.
- Reset mid-frame: assert `rst_n = 0` after 8 bits. Required response:
  - `rx_data = 0`, and no `rdy`/`err` pulse on the `SS_n` rise that follows.
  - A subsequent full frame `16'hBEEF` gives `rdy` and `rx_data = 16'hBEEF`.
- Idle tristate: with `SS_n` high, MISO is `z`. Toggling SCLK causes no `rdy`, `err` or state change.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared constants and types for the 16-bit SPI responder.
package spi_pkg;

   localparam int SPI_WIDTH   = 16;
   localparam int SYNC_STAGES = 2;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } spi_slv_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer plus history flop; flags rising and falling edges
// of an asynchronous pin in the clk domain.
module sync_edge_det
   import spi_pkg::*;
#(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic sync,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   hist_q, hist_d;

   // Shift the pin through the synchronizer; history holds the previous synced value.
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], din};
      hist_d = sync_q[SYNC_STAGES-1];
   end

   // Synchronizer and history registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= {SYNC_STAGES{RST_VAL}};
         hist_q <= RST_VAL;
      end else begin
         sync_q <= sync_d;
         hist_q <= hist_d;
      end
   end

   assign sync = sync_q[SYNC_STAGES-1];
   assign rise = sync & ~hist_q;
   assign fall = ~sync & hist_q;

endmodule

// File: rtl/spi_slv16.sv
// SPI responder, CPOL=1 CPHA=1, MSB first. Oversamples SS_n/SCLK/MOSI in the
// clk domain, returns tx_data on MISO and delivers the received word with rdy.
module spi_slv16
   import spi_pkg::*;
#(
   parameter int WIDTH = SPI_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             SS_n,
   input  logic             SCLK,
   input  logic             MOSI,
   output logic             MISO,
   input  logic [WIDTH-1:0] tx_data,
   output logic [WIDTH-1:0] rx_data,
   output logic             rdy,
   output logic             err
);

   localparam logic [4:0] CNT_FULL = 5'(WIDTH);
   localparam logic [4:0] CNT_MAX  = 5'd31;

   logic ss_s, ss_rise, ss_fall;
   logic sclk_sync_unused, sclk_rise, sclk_fall;
   logic mosi_s;

   logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
   logic [SYNC_STAGES-1:0] prime_q, prime_d;
   logic                   armed_q, armed_d;

   spi_slv_state_t   state_q, state_d;
   logic [WIDTH-1:0] tx_shft_q, tx_shft_d;
   logic [WIDTH-1:0] rx_shft_q, rx_shft_d;
   logic [4:0]       bit_cnt_q, bit_cnt_d;
   logic [WIDTH-1:0] rx_data_q, rx_data_d;
   logic             rdy_q, rdy_d;
   logic             err_q, err_d;

   sync_edge_det #(.RST_VAL(1'b1)) u_ss_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (SS_n),
      .sync (ss_s),
      .rise (ss_rise),
      .fall (ss_fall)
   );

   sync_edge_det #(.RST_VAL(1'b1)) u_sclk_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (SCLK),
      .sync (sclk_sync_unused),
      .rise (sclk_rise),
      .fall (sclk_fall)
   );

   assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

   // MOSI synchronizer and the frame-start qualifier. The SS_n synchronizer
   // resets high, so releasing reset while SS_n is already low would look like
   // a fresh falling edge; a frame may only start once SS_n has genuinely been
   // seen high after the synchronizer has filled with real samples.
   always_comb begin
      mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
      prime_d     = {prime_q[SYNC_STAGES-2:0], 1'b1};
      armed_d     = armed_q | (prime_q[SYNC_STAGES-1] & ss_s);
   end

   // Frame FSM: next state, shift registers, bit counter and result strobes.
   always_comb begin
      state_d   = state_q;
      tx_shft_d = tx_shft_q;
      rx_shft_d = rx_shft_q;
      bit_cnt_d = bit_cnt_q;
      rx_data_d = rx_data_q;
      rdy_d     = 1'b0;
      err_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (ss_fall && armed_q) begin
               tx_shft_d = tx_data;
               rx_shft_d = '0;
               bit_cnt_d = '0;
               state_d   = ACTIVE;
            end
         end
         ACTIVE: begin
            if (sclk_rise) begin
               rx_shft_d = {rx_shft_q[WIDTH-2:0], mosi_s};
               if (bit_cnt_q != CNT_MAX) begin
                  bit_cnt_d = bit_cnt_q + 5'd1;
               end
            end
            // First falling edge leaves the MSB in place; it is already on MISO.
            if (sclk_fall && (bit_cnt_q != 5'd0)) begin
               tx_shft_d = {tx_shft_q[WIDTH-2:0], 1'b0};
            end
            // Uses the updated count so a coincident last rising edge is included.
            if (ss_rise) begin
               if (bit_cnt_d == CNT_FULL) begin
                  rx_data_d = rx_shft_d;
                  rdy_d     = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mosi_sync_q <= '0;
         prime_q     <= '0;
         armed_q     <= 1'b0;
         state_q     <= IDLE;
         tx_shft_q   <= '0;
         rx_shft_q   <= '0;
         bit_cnt_q   <= '0;
         rx_data_q   <= '0;
         rdy_q       <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         mosi_sync_q <= mosi_sync_d;
         prime_q     <= prime_d;
         armed_q     <= armed_d;
         state_q     <= state_d;
         tx_shft_q   <= tx_shft_d;
         rx_shft_q   <= rx_shft_d;
         bit_cnt_q   <= bit_cnt_d;
         rx_data_q   <= rx_data_d;
         rdy_q       <= rdy_d;
         err_q       <= err_d;
      end
   end

   assign MISO    = SS_n ? 1'bz : tx_shft_q[WIDTH-1];
   assign rx_data = rx_data_q;
   assign rdy     = rdy_q;
   assign err     = err_q;

endmodule

// File: tb/tb_spi_slv16.sv
// Directed bench for spi_slv16: a bit-banged SPI master, a scoreboard of
// expected rdy/err results, and per-bit MISO checks.
module tb_spi_slv16;

   typedef struct packed {
      logic        is_err;
      logic [15:0] data;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        SS_n;
   logic        SCLK;
   logic        MOSI;
   logic        MISO;
   logic [15:0] tx_data;
   logic [15:0] rx_data;
   logic        rdy;
   logic        err;

   int          tests_run = 0;
   int          fails     = 0;
   exp_t        sb_q[$];
   logic [15:0] model_rx  = 16'h0000;

   spi_slv16 dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .SS_n   (SS_n),
      .SCLK   (SCLK),
      .MOSI   (MOSI),
      .MISO   (MISO),
      .tx_data(tx_data),
      .rx_data(rx_data),
      .rdy    (rdy),
      .err    (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      assert (got === exp)
      else begin
         fails++;
         $error("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Scoreboard: every rdy/err pulse must match the oldest expected result.
   always @(negedge clk) begin
      exp_t e;
      if (rdy || err) begin
         tests_run++;
         assert (sb_q.size() > 0)
         else begin
            fails++;
            $error("FAIL sb_unexpected: got rdy=%b err=%b, expected no pulse", rdy, err);
         end
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            $display("[TB] frame result rdy=%b err=%b rx_data=%h", rdy, err, rx_data);
            tests_run++;
            assert ({rdy, err} === {~e.is_err, e.is_err})
            else begin
               fails++;
               $error("FAIL sb_kind: got rdy/err=%b%b, expected %b%b", rdy, err, ~e.is_err, e.is_err);
            end
            tests_run++;
            assert (rx_data === e.data)
            else begin
               fails++;
               $error("FAIL sb_rx_data: got %h, expected %h", rx_data, e.data);
            end
         end
      end
   end

   // One SPI frame of nbits; rst_after >= 0 pulses rst_n before that bit.
   task automatic frame(input logic [15:0] tx, input logic [31:0] word,
                        input int nbits, input int rst_after);
      exp_t e;
      bit   no_result;
      bit   exp_rdy;
      bit   exp_err;
      no_result = (rst_after >= 0);
      exp_rdy   = !no_result && (nbits == 16);
      exp_err   = !no_result && (nbits != 16);
      if (!no_result) begin
         e.is_err = exp_err;
         e.data   = exp_rdy ? word[15:0] : model_rx;
         sb_q.push_back(e);
         if (exp_rdy) model_rx = word[15:0];
      end
      tx_data = tx;
      tick(1);
      SS_n = 1'b0;
      tick(16);
      for (int i = 0; i < nbits; i++) begin
         if (i == rst_after) begin
            rst_n = 1'b0;
            tick(2);
            rst_n = 1'b1;
            model_rx = 16'h0000;
            tick(1);
            chk("rst_mid_rx_data", {16'h0, rx_data}, {16'h0, model_rx});
            chk("rst_mid_rdy_err", {30'h0, rdy, err}, 32'h0);
         end
         SCLK = 1'b0;
         MOSI = word[nbits-1-i];
         tick(16);
         SCLK = 1'b1;
         if (rst_after < 0 || i < rst_after) begin
            chk($sformatf("miso_bit%0d", i), {31'h0, MISO},
                {31'h0, (i < 16) ? tx[15-i] : 1'b0});
         end
         tick(16);
      end
      SS_n = 1'b1;
      tick(3);
      chk("pulse_rdy_latency", {31'h0, rdy}, {31'h0, exp_rdy});
      chk("pulse_err_latency", {31'h0, err}, {31'h0, exp_err});
   endtask

   initial begin
      rst_n   = 1'b0;
      SS_n    = 1'b1;
      SCLK    = 1'b1;
      MOSI    = 1'b0;
      tx_data = 16'h0000;
      tick(3);
      chk("reset_rx_data", {16'h0, rx_data}, 32'h0);
      chk("reset_rdy", {31'h0, rdy}, 32'h0);
      chk("reset_err", {31'h0, err}, 32'h0);
      tests_run++;
      assert (MISO === 1'bz)
      else begin
         fails++;
         $error("FAIL reset_miso_z: got %b, expected z", MISO);
      end
      rst_n = 1'b1;
      tick(5);

      // Idle: SCLK/MOSI activity with SS_n high must be ignored.
      for (int i = 0; i < 4; i++) begin
         SCLK = 1'b0;
         MOSI = ~MOSI;
         tick(6);
         tests_run++;
         assert (MISO === 1'bz)
         else begin
            fails++;
            $error("FAIL idle_miso_z: got %b, expected z", MISO);
         end
         SCLK = 1'b1;
         tick(6);
      end
      chk("idle_rx_data", {16'h0, rx_data}, 32'h0);
      $display("[TB] idle toggling done");

      frame(16'hA5C3, 32'h1234, 16, -1);
      chk("frame_rx_data", {16'h0, rx_data}, 32'h1234);
      $display("[TB] frame 1234 exchanged for A5C3");

      frame(16'h0F0F, 32'hFFFF, 16, -1);
      frame(16'h8001, 32'h0001, 16, -1);
      chk("b2b_rx_data", {16'h0, rx_data}, 32'h0001);
      $display("[TB] back-to-back frames done");

      frame(16'h1357, 32'h7ABC, 15, -1);
      chk("short_rx_data", {16'h0, rx_data}, 32'h0001);
      $display("[TB] short frame done");

      frame(16'hC3C3, 32'h1_5A5A, 17, -1);
      chk("long_rx_data", {16'h0, rx_data}, 32'h0001);
      $display("[TB] long frame done");

      frame(16'h2468, 32'hCAFE, 16, 8);
      chk("after_rst_rx_data", {16'h0, rx_data}, 32'h0);
      $display("[TB] mid-frame reset done");

      frame(16'h6E6E, 32'hBEEF, 16, -1);
      chk("beef_rx_data", {16'h0, rx_data}, 32'hBEEF);
      $display("[TB] frame BEEF done");

      tick(10);
      chk("sb_empty", sb_q.size(), 32'h0);
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
